// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg : shared Y86-64 icode/status encodings and memory-stage decode
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package y86_pkg;

  localparam int unsigned WORD_W  = 64;
  localparam int unsigned ICODE_W = 4;
  localparam int unsigned STAT_W  = 3;
  localparam int unsigned DBG_AW  = 16;

  localparam logic [ICODE_W-1:0] ICODE_HALT   = 4'h0;
  localparam logic [ICODE_W-1:0] ICODE_NOP    = 4'h1;
  localparam logic [ICODE_W-1:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] ICODE_OPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] ICODE_JXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICODE_CALL   = 4'h8;
  localparam logic [ICODE_W-1:0] ICODE_RET    = 4'h9;
  localparam logic [ICODE_W-1:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] ICODE_POPQ   = 4'hB;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  typedef struct packed {
    logic rd;
    logic wr;
    logic addr_from_vala;
  } mem_ctl_t;

  function automatic mem_ctl_t decode_mem(input logic [ICODE_W-1:0] icode);
    mem_ctl_t c;
    c.rd             = (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
    c.wr             = (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
    c.addr_from_vala = (icode == ICODE_POPQ) || (icode == ICODE_RET);
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/m_stage_dmem_if.sv
// ---------------------------------------------------------------------------
// m_stage_dmem_if : M-register inputs, debug preload and memory-stage results
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface m_stage_dmem_if
  import y86_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic [STAT_W-1:0]  M_stat;
  logic [ICODE_W-1:0] M_icode;
  logic [WORD_W-1:0]  M_valE;
  logic [WORD_W-1:0]  M_valA;
  logic [STAT_W-1:0]  W_stat;
  logic               dbg_we;
  logic [DBG_AW-1:0]  dbg_addr;
  logic [7:0]         dbg_wdata;
  logic [WORD_W-1:0]  m_valM;
  logic [STAT_W-1:0]  m_stat;
  logic               dmem_error;
  logic               mem_halted;
  logic [CNT_W-1:0]   mem_write_count;

  modport master (
    output M_stat, M_icode, M_valE, M_valA, W_stat, dbg_we, dbg_addr, dbg_wdata,
    input  m_valM, m_stat, dmem_error, mem_halted, mem_write_count
  );

  modport slave (
    input  M_stat, M_icode, M_valE, M_valA, W_stat, dbg_we, dbg_addr, dbg_wdata,
    output m_valM, m_stat, dmem_error, mem_halted, mem_write_count
  );
endinterface

`default_nettype wire

// File: rtl/dmem_bytes.sv
// ---------------------------------------------------------------------------
// dmem_bytes : byte array, async clear, 8-byte LE read/write, byte debug write
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dmem_bytes #(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned AW        = $clog2(MEM_BYTES)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic [AW-1:0] rd_addr_i,
  output logic      [63:0]   rd_data_o,
  input  wire logic          wr_en_i,
  input  wire logic [AW-1:0] wr_addr_i,
  input  wire logic [63:0]   wr_data_i,
  input  wire logic          dbg_we_i,
  input  wire logic [15:0]   dbg_addr_i,
  input  wire logic [7:0]    dbg_wdata_i
);

  logic [7:0] mem_q [MEM_BYTES];
  logic       w_dbg_hit;

  assign w_dbg_hit = dbg_we_i && ({16'd0, dbg_addr_i} < 32'(MEM_BYTES));

  for (genvar k = 0; k < 8; k++) begin : g_rd
    assign rd_data_o[8*k +: 8] = mem_q[rd_addr_i + AW'(k)];
  end

  // Pipeline bytes are assigned after the debug byte so a collision keeps pipeline data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      if (w_dbg_hit) begin
        mem_q[AW'(dbg_addr_i)] <= dbg_wdata_i;
      end
      if (wr_en_i) begin
        for (int k = 0; k < 8; k++) begin
          mem_q[wr_addr_i + AW'(k)] <= wr_data_i[8*k +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/m_stage_dmem.sv
// ---------------------------------------------------------------------------
// m_stage_dmem : Y86-64 PIPE memory stage with data memory and fault latch
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module m_stage_dmem
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8192,
  parameter int unsigned CNT_W     = 32
) (
  input  wire logic     clk,
  input  wire logic     reset,
  m_stage_dmem_if.slave bus
);

  localparam int unsigned        AW       = $clog2(MEM_BYTES);
  localparam logic [WORD_W-1:0]  ADDR_MAX = WORD_W'(MEM_BYTES - 8);

  mem_ctl_t          w_ctl;
  logic [WORD_W-1:0] w_addr;
  logic [WORD_W-1:0] w_rdata;
  logic [STAT_W-1:0] w_stat;
  logic              w_err;
  logic              w_commit;

  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  count_q, count_d;

  always_comb begin
    w_ctl    = decode_mem(bus.M_icode);
    w_addr   = w_ctl.addr_from_vala ? bus.M_valA : bus.M_valE;
    w_err    = (w_ctl.rd || w_ctl.wr) && (w_addr > ADDR_MAX);
    w_stat   = w_err ? STAT_ADR : bus.M_stat;
    w_commit = w_ctl.wr && !w_err && (bus.M_stat == STAT_AOK) &&
               (bus.W_stat == STAT_AOK) && !halted_q;
  end

  always_comb begin
    halted_d = halted_q;
    count_d  = count_q;
    if ((w_stat != STAT_AOK) && (bus.M_icode != ICODE_NOP)) begin
      halted_d = 1'b1;
    end
    if (w_commit && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      halted_q <= halted_d;
      count_q  <= count_d;
    end
  end

  dmem_bytes #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_mem (
    .clk         (clk),
    .reset       (reset),
    .rd_addr_i   (w_addr[AW-1:0]),
    .rd_data_o   (w_rdata),
    .wr_en_i     (w_commit),
    .wr_addr_i   (w_addr[AW-1:0]),
    .wr_data_i   (bus.M_valA),
    .dbg_we_i    (bus.dbg_we),
    .dbg_addr_i  (bus.dbg_addr),
    .dbg_wdata_i (bus.dbg_wdata)
  );

  // Reads are forced to zero while reset is held, independent of the clear's progress.
  assign bus.m_valM          = (w_ctl.rd && !w_err && !reset) ? w_rdata : '0;
  assign bus.m_stat          = w_stat;
  assign bus.dmem_error      = w_err;
  assign bus.mem_halted      = halted_q;
  assign bus.mem_write_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_m_stage_dmem.sv
// ---------------------------------------------------------------------------
// tb_m_stage_dmem : randomized self-checking bench with a byte-array memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_m_stage_dmem;

  localparam int MB = 8192;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  m_stage_dmem_if #(.CNT_W(CW)) bus ();

  m_stage_dmem #(.MEM_BYTES(MB), .CNT_W(CW)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  byte unsigned ref_mem [MB];
  bit           ref_halted;
  int           ref_count;

  // ---------------- reference model ----------------
  task automatic ref_clear();
    for (int i = 0; i < MB; i++) ref_mem[i] = 8'h00;
    ref_halted = 1'b0;
    ref_count  = 0;
  endtask

  function automatic bit ref_is_rd();
    return bus.M_icode == 4'h5 || bus.M_icode == 4'hB || bus.M_icode == 4'h9;
  endfunction

  function automatic bit ref_is_wr();
    return bus.M_icode == 4'h4 || bus.M_icode == 4'hA || bus.M_icode == 4'h8;
  endfunction

  function automatic logic [63:0] ref_addr();
    return (bus.M_icode == 4'hB || bus.M_icode == 4'h9) ? bus.M_valA : bus.M_valE;
  endfunction

  function automatic bit ref_err();
    return (ref_is_rd() || ref_is_wr()) && (ref_addr() > 64'(MB - 8));
  endfunction

  function automatic logic [2:0] ref_stat();
    return ref_err() ? 3'd3 : bus.M_stat;
  endfunction

  function automatic logic [63:0] ref_valM();
    logic [63:0] r = 64'd0;
    int a;
    if (!ref_is_rd() || ref_err()) return 64'd0;
    a = int'(ref_addr());
    for (int k = 0; k < 8; k++) r[8*k +: 8] = ref_mem[a + k];
    return r;
  endfunction

  // Applies what the coming clock edge must do, given the currently driven inputs.
  task automatic ref_edge();
    bit commit;
    int a;
    commit = ref_is_wr() && !ref_err() && bus.M_stat == 3'd1 && bus.W_stat == 3'd1 && !ref_halted;
    if (bus.dbg_we && int'(bus.dbg_addr) < MB) ref_mem[int'(bus.dbg_addr)] = bus.dbg_wdata;
    if (commit) begin
      a = int'(ref_addr());
      for (int k = 0; k < 8; k++) ref_mem[a + k] = bus.M_valA[8*k +: 8];
      if (ref_count < CNT_MAX) ref_count++;
    end
    if (ref_stat() != 3'd1 && bus.M_icode != 4'h1) ref_halted = 1'b1;
  endtask

  task automatic drive(input logic [2:0] ms, input logic [3:0] ic,
                       input logic [63:0] ve, input logic [63:0] va, input logic [2:0] ws);
    bus.M_stat    = ms;
    bus.M_icode   = ic;
    bus.M_valE    = ve;
    bus.M_valA    = va;
    bus.W_stat    = ws;
    bus.dbg_we    = 1'b0;
    bus.dbg_addr  = 16'd0;
    bus.dbg_wdata = 8'd0;
  endtask

  task automatic tick();
    ref_edge();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    drive(3'd1, 4'h5, 64'h40, 64'd0, 3'd1);
    #1 reset = 1'b1;
    #1;
    ref_clear();
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL reset_valM: got %h want 0", bus.m_valM); end
    n_cmp++; if (bus.mem_halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted: got %b want 0", bus.mem_halted); end
    n_cmp++; if (bus.mem_write_count !== CW'(0)) begin n_bad++; $display("FAIL reset_count: got %0d want 0", bus.mem_write_count); end
    n_cmp++; if (bus.m_stat !== 3'd1) begin n_bad++; $display("FAIL reset_stat: got %0d want 1", bus.m_stat); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_wstat_suppress();
    drive(3'd1, 4'hA, 64'h200, 64'hDEAD_BEEF_0BAD_F00D, 3'd2);
    #1;
    n_cmp++; if (bus.dmem_error !== 1'b0) begin n_bad++; $display("FAIL wstat_err: got %b want 0", bus.dmem_error); end
    tick();
    drive(3'd1, 4'h5, 64'h200, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL wstat_nowrite: got %h want 0", bus.m_valM); end
    n_cmp++; if (bus.mem_write_count !== CW'(0)) begin n_bad++; $display("FAIL wstat_count: got %0d want 0", bus.mem_write_count); end
    n_cmp++; if (bus.mem_halted !== 1'b0) begin n_bad++; $display("FAIL wstat_halted: got %b want 0", bus.mem_halted); end
    tick();
  endtask

  task automatic test_rw_basic();
    drive(3'd1, 4'h4, 64'h100, 64'h1122_3344_5566_7788, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL store_valM: got %h want 0", bus.m_valM); end
    tick();
    drive(3'd1, 4'h5, 64'h100, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'h1122_3344_5566_7788) begin n_bad++; $display("FAIL rw_read: got %h want 1122334455667788", bus.m_valM); end
    n_cmp++; if (bus.m_valM[7:0] !== 8'h88) begin n_bad++; $display("FAIL rw_byte0: got %h want 88", bus.m_valM[7:0]); end
    n_cmp++; if (bus.mem_write_count !== CW'(1)) begin n_bad++; $display("FAIL rw_count: got %0d want 1", bus.mem_write_count); end
    tick();
  endtask

  task automatic test_dbg_preload();
    for (int i = 0; i < 8; i++) begin
      drive(3'd1, 4'h1, 64'd0, 64'd0, 3'd1);
      bus.dbg_we    = 1'b1;
      bus.dbg_addr  = 16'(32'h200 + i);
      bus.dbg_wdata = 8'(i + 1);
      tick();
    end
    drive(3'd1, 4'hB, 64'h208, 64'h200, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'h0807_0605_0403_0201) begin n_bad++; $display("FAIL popq_read: got %h want 0807060504030201", bus.m_valM); end
    drive(3'd1, 4'h9, 64'h0, 64'h200, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'h0807_0605_0403_0201) begin n_bad++; $display("FAIL ret_read: got %h want 0807060504030201", bus.m_valM); end
    drive(3'd1, 4'h1, 64'h200, 64'h200, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL bubble_valM: got %h want 0", bus.m_valM); end
    tick();
  endtask

  task automatic test_dbg_collision();
    drive(3'd1, 4'h4, 64'h300, 64'h55, 3'd1);
    bus.dbg_we    = 1'b1;
    bus.dbg_addr  = 16'h300;
    bus.dbg_wdata = 8'hAA;
    tick();
    drive(3'd1, 4'h5, 64'h300, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'h55) begin n_bad++; $display("FAIL collide_read: got %h want 55", bus.m_valM); end
    tick();
  endtask

  task automatic test_boundary();
    drive(3'd1, 4'h8, 64'(MB - 8), 64'hA5A5_0000_1234_5678, 3'd1);
    #1;
    n_cmp++; if (bus.dmem_error !== 1'b0) begin n_bad++; $display("FAIL edge_err: got %b want 0", bus.dmem_error); end
    tick();
    drive(3'd1, 4'h5, 64'(MB - 8), 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'hA5A5_0000_1234_5678) begin n_bad++; $display("FAIL edge_read: got %h want a5a5000012345678", bus.m_valM); end
    n_cmp++; if (bus.m_stat !== 3'd1) begin n_bad++; $display("FAIL edge_stat: got %0d want 1", bus.m_stat); end
    tick();
  endtask

  function automatic logic [63:0] gen_addr(input bit allow_fault);
    case ($urandom_range(0, 3))
      0: return 64'($urandom_range(0, 63));
      1: return 64'($urandom_range(0, MB - 8));
      2: return 64'(MB - 8 - $urandom_range(0, 8));
      default: begin
        if (!allow_fault) return 64'($urandom_range(0, MB - 8));
        if ($urandom_range(0, 1) == 0) return 64'(MB - 7 + $urandom_range(0, 20));
        return {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      end
    endcase
  endfunction

  task automatic test_random();
    logic [3:0] ic;
    logic [2:0] ms, ws;
    logic [63:0] ve, va;
    bit flt;
    for (int i = 0; i < 400; i++) begin
      flt = (i >= 330);
      ic  = 4'($urandom_range(0, 11));
      ms  = (flt && $urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      ws  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      if (!flt && ic == 4'h0) ic = 4'h1;
      ve  = gen_addr(flt);
      va  = (ic == 4'hB || ic == 4'h9) ? gen_addr(flt) : {$urandom, $urandom};
      drive(ms, ic, ve, va, ws);
      if ($urandom_range(0, 3) == 0) begin
        bus.dbg_we    = 1'b1;
        bus.dbg_addr  = 16'($urandom_range(0, MB + 100));
        bus.dbg_wdata = 8'($urandom);
      end
      #1;
      n_cmp++; if (bus.m_valM !== ref_valM()) begin n_bad++; $display("FAIL rnd_valM[%0d]: got %h want %h", i, bus.m_valM, ref_valM()); end
      n_cmp++; if (bus.m_stat !== ref_stat()) begin n_bad++; $display("FAIL rnd_stat[%0d]: got %0d want %0d", i, bus.m_stat, ref_stat()); end
      n_cmp++; if (bus.dmem_error !== ref_err()) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", i, bus.dmem_error, ref_err()); end
      n_cmp++; if (bus.mem_halted !== ref_halted) begin n_bad++; $display("FAIL rnd_halted[%0d]: got %b want %b", i, bus.mem_halted, ref_halted); end
      n_cmp++; if (bus.mem_write_count !== CW'(ref_count)) begin n_bad++; $display("FAIL rnd_count[%0d]: got %0d want %0d", i, bus.mem_write_count, ref_count); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(3'd1, 4'h1, 64'd0, 64'd0, 3'd1);
    bus.dbg_we = 1'b1; bus.dbg_addr = 16'h100; bus.dbg_wdata = 8'h5A;
    tick();
    drive(3'd4, 4'h5, 64'h100, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== ref_valM()) begin n_bad++; $display("FAIL pre_reset_read: got %h want %h", bus.m_valM, ref_valM()); end
    #2 reset = 1'b1;
    #1;
    ref_clear();
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL async_valM: got %h want 0", bus.m_valM); end
    n_cmp++; if (bus.mem_halted !== 1'b0) begin n_bad++; $display("FAIL async_halted: got %b want 0", bus.mem_halted); end
    n_cmp++; if (bus.mem_write_count !== CW'(0)) begin n_bad++; $display("FAIL async_count: got %0d want 0", bus.mem_write_count); end
    n_cmp++; if (bus.m_stat !== 3'd4) begin n_bad++; $display("FAIL async_stat: got %0d want 4", bus.m_stat); end
    @(negedge clk);
    reset = 1'b0;
    drive(3'd1, 4'h1, 64'd0, 64'd0, 3'd1);
    @(posedge clk); #1;
  endtask

  task automatic test_fault();
    drive(3'd2, 4'h1, 64'd0, 64'd0, 3'd1);
    tick();
    n_cmp++; if (bus.mem_halted !== 1'b0) begin n_bad++; $display("FAIL bubble_nohalt: got %b want 0", bus.mem_halted); end
    drive(3'd1, 4'h5, 64'(MB - 7), 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.dmem_error !== 1'b1) begin n_bad++; $display("FAIL oob_err: got %b want 1", bus.dmem_error); end
    n_cmp++; if (bus.m_stat !== 3'd3) begin n_bad++; $display("FAIL oob_stat: got %0d want 3", bus.m_stat); end
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL oob_valM: got %h want 0", bus.m_valM); end
    tick();
    n_cmp++; if (bus.mem_halted !== 1'b1) begin n_bad++; $display("FAIL oob_halted: got %b want 1", bus.mem_halted); end
    drive(3'd1, 4'h4, 64'h0, 64'hFFFF_0000_FFFF_0000, 3'd1);
    bus.dbg_we = 1'b1; bus.dbg_addr = 16'h10; bus.dbg_wdata = 8'h77;
    tick();
    drive(3'd1, 4'h5, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.dmem_error !== 1'b1) begin n_bad++; $display("FAIL wrap_err: got %b want 1", bus.dmem_error); end
    drive(3'd1, 4'h5, 64'h0, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM !== 64'd0) begin n_bad++; $display("FAIL halted_nowrite: got %h want 0", bus.m_valM); end
    n_cmp++; if (bus.mem_write_count !== CW'(0)) begin n_bad++; $display("FAIL halted_count: got %0d want 0", bus.mem_write_count); end
    drive(3'd1, 4'h5, 64'h10, 64'd0, 3'd1);
    #1;
    n_cmp++; if (bus.m_valM[7:0] !== 8'h77) begin n_bad++; $display("FAIL halted_dbg: got %h want 77", bus.m_valM[7:0]); end
    tick();
  endtask

  initial begin
    test_reset();
    test_wstat_suppress();
    test_rw_basic();
    test_dbg_preload();
    test_dbg_collision();
    test_boundary();
    test_random();
    test_async_reset();
    test_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
